// File: rtl/instr_encoder_if.sv
// Field-bundle input handshake and encoded-word output handshake of the instruction encoder.
// The encoder itself connects through the slave modport.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;

  modport master (
    output in_valid, opcode, rd, rs1, rs2, funct3, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  in_valid, opcode, rd, rs1, rs2, funct3, imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs RISC-V style I/S/B/J field bundles into 32-bit words with a single registered output stage.
// Bundles that cannot be encoded become NOPs that still take an address and bump the error count.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h00000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  instr_encoder_if.slave   bus,
  output logic [7:0]       err_count
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [2:0] {
    CLS_I,
    CLS_S,
    CLS_B,
    CLS_J,
    CLS_BAD
  } enc_class_t;

  enc_class_t  enc_class;
  logic [31:0] imm;
  logic [31:0] raw_word;
  logic [31:0] enc_word;
  logic        enc_err;
  logic        imm12_ok;
  logic        imm13_ok;
  logic        imm21_ok;
  logic        accept;
  logic [31:0] addr_cnt;
  logic [31:0] cur_addr;
  logic [7:0]  cnt_base;

  assign imm = bus.imm;

  // An immediate fits an N-bit signed field when every bit above the field's sign bit copies it.
  assign imm12_ok = (&imm[31:11]) || !(|imm[31:11]);
  assign imm13_ok = (&imm[31:12]) || !(|imm[31:12]);
  assign imm21_ok = (&imm[31:20]) || !(|imm[31:20]);

  always_comb begin
    enc_class = CLS_BAD;
    case (bus.opcode)
      7'b0010011, 7'b0000011, 7'b0001011: enc_class = CLS_I;
      7'b0100011, 7'b0101011:             enc_class = CLS_S;
      7'b1100011:                         enc_class = CLS_B;
      7'b1101111:                         enc_class = CLS_J;
      default:                            enc_class = CLS_BAD;
    endcase
  end

  always_comb begin
    raw_word = NOP;
    enc_err  = 1'b0;
    case (enc_class)
      CLS_I: begin
        raw_word = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        enc_err  = !imm12_ok;
      end
      CLS_S: begin
        raw_word = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode};
        enc_err  = !imm12_ok;
      end
      CLS_B: begin
        raw_word = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                    imm[4:1], imm[11], bus.opcode};
        enc_err  = !imm13_ok || imm[0];
      end
      CLS_J: begin
        raw_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
        enc_err  = !imm21_ok || imm[0];
      end
      default: begin
        raw_word = NOP;
        enc_err  = 1'b1;
      end
    endcase
    enc_word = enc_err ? NOP : raw_word;
  end

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // clr takes effect in the same cycle, so a word accepted alongside it sees the restarted counters.
  assign cur_addr = clr ? BASE_ADDR : addr_cnt;
  assign cnt_base = clr ? 8'd0 : err_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_instr <= 32'd0;
      bus.out_addr  <= BASE_ADDR;
      bus.out_err   <= 1'b0;
      addr_cnt      <= BASE_ADDR;
      err_count     <= 8'd0;
    end else begin
      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.out_instr <= enc_word;
        bus.out_addr  <= cur_addr;
        bus.out_err   <= enc_err;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      addr_cnt <= accept ? cur_addr + 32'd4 : cur_addr;

      if (accept && enc_err && (cnt_base != 8'hFF)) begin
        err_count <= cnt_base + 8'd1;
      end else begin
        err_count <= cnt_base;
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h00000000: address assigned to the first encoded word after reset or clr.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port clr, input, 1: synchronous restart of the address counter and error counter; output stage is not affected.
REQ-005 SHALL have port in_valid, input, 1: field bundle valid.
REQ-006 SHALL have port in_ready, output, 1: encoder can accept a bundle.
REQ-007 SHALL have port opcode, input, 7: instruction opcode.
REQ-008 SHALL have ports rd, rs1 and rs2, input, 5 each: register indices.
REQ-009 SHALL have port funct3, input, 3: minor opcode.
REQ-010 SHALL have port imm, input, 32: signed immediate, byte offset for branch/jump.
REQ-011 SHALL have port out_valid, output, 1: encoded word valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the word.
REQ-013 SHALL have port out_instr, output, 32: encoded instruction.
REQ-014 SHALL have port out_addr, output, 32: instruction-memory address of out_instr.
REQ-015 SHALL have port out_err, output, 1: the word is a substituted NOP because of an encode error.
REQ-016 SHALL have port err_count, output, 8: count of encode errors, saturating.

Function
REQ-017 SHALL accept a bundle when in_valid && in_ready.
- in_ready = !out_valid || out_ready (single output register, combinational ready).
REQ-018 SHALL register the encoded result one cycle after acceptance: out_valid=1 and out_instr/out_addr/out_err valid.
- Latency is 1 cycle.
- Full throughput of 1 word/cycle when out_ready is held high.
REQ-019 SHALL hold out_instr, out_addr and out_err stable while out_valid && !out_ready.
REQ-020 SHALL clear out_valid after a transfer (out_valid && out_ready) when no new bundle is accepted in the same cycle.
REQ-021 SHALL encode each opcode class as follows:
- I/load (0010011, 0000011, 0001011): {imm[11:0], rs1, funct3, rd, opcode}.
- S (0100011, 0101011): {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- B (1100011): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- J (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-022 SHALL flag an encode error under any of these conditions:
- I/S immediate outside -2048..2047 (imm[31:11] not all equal).
- B immediate outside -4096..4094 (imm[31:12] not all equal) or imm[0]=1.
- J immediate outside +/-1 MiB (imm[31:20] not all equal) or imm[0]=1.
- Any opcode not listed in REQ-021.
REQ-023 SHALL, on an encode error, output out_instr=32'h00000013 (NOP) with out_err=1.
- The word still consumes an address.
REQ-024 SHALL meet the round-trip property: for every error-free word, sign-extended immediate decoding of out_instr returns imm exactly.
REQ-025 SHALL assign out_addr from an address counter.
- The counter starts at BASE_ADDR and increments by 4 on each accepted bundle.
- The counter wraps modulo 2^32.
REQ-026 SHALL increment err_count on each accepted erroneous bundle and saturate at 255.
REQ-027 SHALL, when clr and an acceptance occur in the same cycle, give the accepted word address BASE_ADDR, set the counter to BASE_ADDR+4, and set err_count to 0 or 1 according to that word's error status.

Reset
REQ-028 SHALL, on reset, set out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, err_count=0 and the address counter to BASE_ADDR.
REQ-029 SHALL give reset priority over clr and acceptance.
- A word held mid-stall is discarded.
- in_ready=1 in the first cycle after reset.

Verification
REQ-030 SHALL verify ADDI: opcode=0010011, rd=1, rs1=0, funct3=0, imm=5 -> next cycle out_instr=0x00500093, out_addr=0x0, out_err=0.
REQ-031 SHALL verify SW: opcode=0100011, rs1=3, rs2=2, funct3=010, imm=-4 -> out_instr=0xFE21AE23.
REQ-032 SHALL verify BEQ: opcode=1100011, rs1=1, rs2=2, funct3=0, imm=8 -> out_instr=0x00208463.
REQ-033 SHALL verify error path: ADDI with imm=2048, then a BEQ with imm=3 -> both words 0x00000013 with out_err=1, err_count=2, addresses 0x0 and 0x4.
REQ-034 SHALL verify backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; raising out_ready -> one transfer per cycle with consecutive addresses.
REQ-035 SHALL verify reset during stall: reset with out_valid=1 -> out_valid=0; the next word gets out_addr=BASE_ADDR.
